iob_axistream_in_packer: RTL and testbench



---
 rtl/iob_axistream_in_packer.sv | 169 ++++++++++++++++
 tb/tb_iob_axistream_in_packer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/iob_axistream_in_packer.sv
// Multi-channel AXI-Stream input packer: round-robin packet arbitration across
// N_CH narrow streams, packing beats into DATA_W words tagged with channel/lanes/tlast.
module iob_axistream_in_packer #(
    parameter int N_CH    = 2,
    parameter int TDATA_W = 8,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    localparam int R      = DATA_W / TDATA_W,
    localparam int LANE_W = (R > 1) ? $clog2(R) : 1,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int NL_W   = $clog2(R + 1)
) (
    input  logic                    clk_i,
    input  logic                    cke_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [N_CH-1:0]         axis_tvalid_i,
    output logic [N_CH-1:0]         axis_tready_o,
    input  logic [N_CH*TDATA_W-1:0] axis_tdata_i,
    input  logic [N_CH-1:0]         axis_tlast_i,
    output logic                    m_tvalid_o,
    input  logic                    m_tready_i,
    output logic [DATA_W-1:0]       m_tdata_o,
    output logic                    m_tlast_o,
    output logic [CH_W-1:0]         m_tch_o,
    output logic [NL_W-1:0]         m_nlanes_o,
    output logic [N_CH*CNT_W-1:0]   beat_cnt_o,
    output logic                    busy_o
);

    typedef enum logic [1:0] {IDLE, PACK, OUT} state_t;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    grant_q, grant_d;
    logic [CH_W-1:0]    ptr_q, ptr_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [NL_W-1:0]    nlanes_q, nlanes_d;
    logic               last_q, last_d;
    logic [N_CH-1:0]    tready_q, tready_d;
    logic [CNT_W-1:0]   cnt_q [N_CH];
    logic [CNT_W-1:0]   cnt_d [N_CH];
    logic [CH_W-1:0]    pick_s;

    // Round-robin search starting just after the last served channel
    always_comb begin
        int idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        pick_s = '0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = (int'(ptr_q) + i) % N_CH;
            if (!found && axis_tvalid_i[idx]) begin
                pick_s = CH_W'(idx);
                found  = 1'b1;
            end else begin
                found  = found;
            end
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        lane_d   = lane_q;
        data_d   = data_q;
        nlanes_d = nlanes_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        tready_d = '0;
        case (state_q)
            IDLE: begin
                if (enable_i && (|axis_tvalid_i)) begin
                    grant_d = pick_s;
                    lane_d  = '0;
                    // Starting from a cleared word leaves unused upper lanes zero
                    data_d  = '0;
                    state_d = PACK;
                end else begin
                    state_d = IDLE;
                end
            end
            PACK: begin
                if (axis_tvalid_i[grant_q] && tready_q[grant_q]) begin
                    data_d[lane_q*TDATA_W +: TDATA_W] = axis_tdata_i[grant_q*TDATA_W +: TDATA_W];
                    if (cnt_q[grant_q] != {CNT_W{1'b1}}) begin
                        cnt_d[grant_q] = cnt_q[grant_q] + CNT_W'(1);
                    end else begin
                        cnt_d[grant_q] = cnt_q[grant_q];
                    end
                    if ((lane_q == LANE_W'(R - 1)) || axis_tlast_i[grant_q]) begin
                        nlanes_d = NL_W'(lane_q) + NL_W'(1);
                        last_d   = axis_tlast_i[grant_q];
                        state_d  = OUT;
                    end else begin
                        lane_d   = lane_q + LANE_W'(1);
                    end
                end else begin
                    state_d = PACK;
                end
            end
            OUT: begin
                if (m_tready_i) begin
                    if (last_q) begin
                        ptr_d   = grant_q;
                        state_d = IDLE;
                    end else begin
                        data_d  = '0;
                        lane_d  = '0;
                        state_d = PACK;
                    end
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d == PACK) begin
            tready_d[grant_d] = 1'b1;
        end else begin
            tready_d = '0;
        end
    end

    // State registers with clock enable and synchronous reset
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                state_q  <= IDLE;
                grant_q  <= '0;
                ptr_q    <= CH_W'(N_CH - 1);
                lane_q   <= '0;
                data_q   <= '0;
                nlanes_q <= '0;
                last_q   <= 1'b0;
                tready_q <= '0;
                for (int c = 0; c < N_CH; c++) cnt_q[c] <= '0;
            end else begin
                state_q  <= state_d;
                grant_q  <= grant_d;
                ptr_q    <= ptr_d;
                lane_q   <= lane_d;
                data_q   <= data_d;
                nlanes_q <= nlanes_d;
                last_q   <= last_d;
                tready_q <= tready_d;
                for (int c = 0; c < N_CH; c++) cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign axis_tready_o = tready_q;
    assign m_tvalid_o    = (state_q == OUT);
    assign m_tdata_o     = data_q;
    assign m_tlast_o     = last_q;
    assign m_tch_o       = grant_q;
    assign m_nlanes_o    = nlanes_q;
    assign busy_o        = (state_q != IDLE);

    for (genvar c = 0; c < N_CH; c++) begin : g_cnt
        assign beat_cnt_o[c*CNT_W +: CNT_W] = cnt_q[c];
    end

endmodule

// File: tb/tb_iob_axistream_in_packer.sv
// Directed bench: a 4-lane packer (8->32) and a 1-lane packer (8->8), both two channels.
module tb_iob_axistream_in_packer;

    logic clk = 1'b0;
    logic cke, rst, en4, en8, mrdy4, mrdy8;
    logic       tv [4];
    logic [7:0] td [4];
    logic       tl [4];

    logic [1:0]  tready4, tready8;
    logic        mv4, ml4, mch4, mv8, ml8, mch8, nl8, busy4, busy8;
    logic [31:0] md4;
    logic [7:0]  md8;
    logic [2:0]  nl4;
    logic [31:0] cnt4, cnt8;

    logic [63:0] q4[$];
    logic [63:0] q8[$];
    int n_vec = 0;
    int n_err = 0;
    int both_cnt = 0;

    always #5 clk = ~clk;

    iob_axistream_in_packer #(.N_CH(2), .TDATA_W(8), .DATA_W(32), .CNT_W(16)) u_dut4 (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .enable_i(en4),
        .axis_tvalid_i({tv[1], tv[0]}), .axis_tready_o(tready4),
        .axis_tdata_i({td[1], td[0]}), .axis_tlast_i({tl[1], tl[0]}),
        .m_tvalid_o(mv4), .m_tready_i(mrdy4), .m_tdata_o(md4), .m_tlast_o(ml4),
        .m_tch_o(mch4), .m_nlanes_o(nl4), .beat_cnt_o(cnt4), .busy_o(busy4));

    iob_axistream_in_packer #(.N_CH(2), .TDATA_W(8), .DATA_W(8), .CNT_W(16)) u_dut8 (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .enable_i(en8),
        .axis_tvalid_i({tv[3], tv[2]}), .axis_tready_o(tready8),
        .axis_tdata_i({td[3], td[2]}), .axis_tlast_i({tl[3], tl[2]}),
        .m_tvalid_o(mv8), .m_tready_i(mrdy8), .m_tdata_o(md8), .m_tlast_o(ml8),
        .m_tch_o(mch8), .m_nlanes_o(nl8), .beat_cnt_o(cnt8), .busy_o(busy8));

    function automatic logic [63:0] mkw(input logic [3:0] ch, input logic [3:0] nl,
                                        input logic last, input logic [31:0] d);
        return {20'd0, ch, nl, 3'd0, last, d};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Word monitor: a handshake seen here completes at the next rising edge
    always @(negedge clk) begin
        if (cke && mv4 && mrdy4) q4.push_back(mkw({3'd0, mch4}, {1'b0, nl4}, ml4, md4));
        if (cke && mv8 && mrdy8) q8.push_back(mkw({3'd0, mch8}, {3'd0, nl8}, ml8, {24'd0, md8}));
        if (tready4 == 2'b11) both_cnt++;
    end

    task automatic send_beat(input int idx, input logic [7:0] d, input logic l);
        int n;
        logic [3:0] rdy;
        tv[idx] = 1'b1; td[idx] = d; tl[idx] = l;
        n = 0;
        do begin
            @(negedge clk);
            rdy = {tready8, tready4};
            n++;
        end while (!rdy[idx] && n < 300);
        if (!rdy[idx]) check_eq("tready_timeout", {63'd0, rdy[idx]}, 64'd1);
        @(posedge clk); #1;
        tv[idx] = 1'b0; tl[idx] = 1'b0;
    endtask

    task automatic expect_word(input int dut, input string tag, input logic [63:0] exp);
        int n;
        logic [63:0] w;
        n = 0;
        while (((dut == 4) ? q4.size() : q8.size()) == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (((dut == 4) ? q4.size() : q8.size()) == 0) w = {64{1'bx}};
        else if (dut == 4) w = q4.pop_front();
        else w = q8.pop_front();
        check_eq(tag, w, exp);
    endtask

    initial begin
        cke = 1'b1; rst = 1'b1; en4 = 1'b1; en8 = 1'b0; mrdy4 = 1'b1; mrdy8 = 1'b1;
        for (int i = 0; i < 4; i++) begin tv[i] = 1'b0; td[i] = 8'd0; tl[i] = 1'b0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_tready", {62'd0, tready4}, 64'd0);
        check_eq("rst_tvalid", {63'd0, mv4}, 64'd0);
        check_eq("rst_word", mkw({3'd0, mch4}, {1'b0, nl4}, ml4, md4), 64'd0);
        check_eq("rst_cnt", {32'd0, cnt4}, 64'd0);
        check_eq("rst_busy", {62'd0, busy8, busy4}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Eight beats on ch0 -> two full words
        for (int i = 1; i <= 8; i++) send_beat(0, 8'(i), (i == 8));
        expect_word(4, "a_w0", mkw(4'd0, 4'd4, 1'b0, 32'h04030201));
        expect_word(4, "a_w1", mkw(4'd0, 4'd4, 1'b1, 32'h08070605));
        check_eq("a_cnt0", {48'd0, cnt4[15:0]}, 64'd8);

        // Five beats -> full word then zero-padded single lane
        for (int i = 0; i < 5; i++) send_beat(0, 8'h11 + 8'(i), (i == 4));
        expect_word(4, "b_w0", mkw(4'd0, 4'd4, 1'b0, 32'h14131211));
        expect_word(4, "b_w1", mkw(4'd0, 4'd1, 1'b1, 32'h00000015));
        check_eq("b_cnt0", {48'd0, cnt4[15:0]}, 64'd13);

        // Downstream back-pressure in OUT
        @(posedge clk); #1 mrdy4 = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(1, 8'hC0 + 8'(i), (i == 3));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("m_hold_valid", {63'd0, mv4}, 64'd1);
            check_eq("m_hold_word", mkw({3'd0, mch4}, {1'b0, nl4}, ml4, md4),
                     mkw(4'd1, 4'd4, 1'b1, 32'hC3C2C1C0));
            check_eq("m_hold_tready", {62'd0, tready4}, 64'd0);
        end
        @(posedge clk); #1 cke = 1'b0; mrdy4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("cke_hold_valid", {63'd0, mv4}, 64'd1);
        end
        @(posedge clk); #1 cke = 1'b1;
        expect_word(4, "m_word", mkw(4'd1, 4'd4, 1'b1, 32'hC3C2C1C0));
        check_eq("b_cnt1", {48'd0, cnt4[31:16]}, 64'd4);

        // Reset in the middle of a ch1 packet
        @(posedge clk); #1;
        send_beat(1, 8'hD0, 1'b0);
        send_beat(1, 8'hD1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("r_busy", {63'd0, busy4}, 64'd0);
        check_eq("r_tvalid", {63'd0, mv4}, 64'd0);
        check_eq("r_word", mkw({3'd0, mch4}, {1'b0, nl4}, ml4, md4), 64'd0);
        check_eq("r_cnt", {32'd0, cnt4}, 64'd0);
        check_eq("r_tready", {62'd0, tready4}, 64'd0);
        repeat (5) @(negedge clk);
        check_eq("r_dropped", 64'(q4.size()), 64'd0);

        // Both channels contend with back-to-back 2-beat packets
        @(posedge clk); #1;
        fork
            begin
                send_beat(0, 8'hA0, 1'b0); send_beat(0, 8'hA1, 1'b1);
                send_beat(0, 8'hA2, 1'b0); send_beat(0, 8'hA3, 1'b1);
            end
            begin
                send_beat(1, 8'hB0, 1'b0); send_beat(1, 8'hB1, 1'b1);
                send_beat(1, 8'hB2, 1'b0); send_beat(1, 8'hB3, 1'b1);
            end
        join
        expect_word(4, "c_w0", mkw(4'd0, 4'd2, 1'b1, 32'h0000A1A0));
        expect_word(4, "c_w1", mkw(4'd1, 4'd2, 1'b1, 32'h0000B1B0));
        expect_word(4, "c_w2", mkw(4'd0, 4'd2, 1'b1, 32'h0000A3A2));
        expect_word(4, "c_w3", mkw(4'd1, 4'd2, 1'b1, 32'h0000B3B2));
        check_eq("c_tready_excl", 64'(both_cnt), 64'd0);
        check_eq("c_cnt", {32'd0, cnt4}, {32'd0, 16'd4, 16'd4});

        // Single-lane packer: no grant while disabled, then one word per beat
        @(posedge clk); #1;
        tv[3] = 1'b1; td[3] = 8'h31;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("e_busy", {62'd0, tready8, busy8}, 64'd0);
        end
        @(posedge clk); #1 en8 = 1'b1;
        send_beat(3, 8'h31, 1'b0);
        send_beat(3, 8'h32, 1'b0);
        send_beat(3, 8'h33, 1'b1);
        expect_word(8, "r1_w0", mkw(4'd1, 4'd1, 1'b0, 32'h31));
        expect_word(8, "r1_w1", mkw(4'd1, 4'd1, 1'b0, 32'h32));
        expect_word(8, "r1_w2", mkw(4'd1, 4'd1, 1'b1, 32'h33));
        check_eq("r1_cnt", {32'd0, cnt8}, {32'd0, 16'd3, 16'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
